fir_tap_accumulator: RTL and testbench



---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_tap_accumulator.sv | 153 +++++++++++++++
 tb/tb_fir_tap_accumulator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the pedal FIR equalizer datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default widths used by both the coefficient-multiplier stage and
// the tap accumulator, the tap count, and the unsigned output clip function.
package fir_pkg;

  localparam int PW_DEFAULT    = 18;  // tap product width
  localparam int AW_DEFAULT    = 22;  // accumulator width
  localparam int OW_DEFAULT    = 8;   // output sample width
  localparam int SHIFT_DEFAULT = 10;  // gain normalisation shift
  localparam int NTAPS         = 16;  // taps per frame

  // Unsigned clip of v to the range [0, 2^ow - 1]. Operates on a 64-bit
  // carrier so callers with any width up to 64 can share it; the caller
  // narrows the result to its own output width.
  function automatic logic [63:0] sat_u(input logic [63:0] v, input int ow);
    logic [63:0] lim;
    lim = (64'd1 << ow) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fir_tap_accumulator.sv
// Purpose: sums 16 captured tap products serially, scales, clips to OW bits.
// Latency: 17 clocks from the edge sampling the ready rise to dout_valid.
// Backpressure: none; a ready rise while busy is dropped and flags ovr.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   datain0..datain15   unsigned tap products, valid while rdy_in is high
//   rdy_in              level ready from the multiplier; its rise starts a frame
//   clr_ovr             synchronous clear of the sticky overrun flag
//   dout                clipped sample, held until the next result
//   dout_valid          one-cycle pulse when dout updates
//   busy                high while a frame is in ACC or DONE
//   ovr                 sticky: a frame start arrived while not idle
module fir_tap_accumulator
  import fir_pkg::*;
#(
  parameter int PW    = PW_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT,
  parameter int OW    = OW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] datain0,
  input  logic [PW-1:0] datain1,
  input  logic [PW-1:0] datain2,
  input  logic [PW-1:0] datain3,
  input  logic [PW-1:0] datain4,
  input  logic [PW-1:0] datain5,
  input  logic [PW-1:0] datain6,
  input  logic [PW-1:0] datain7,
  input  logic [PW-1:0] datain8,
  input  logic [PW-1:0] datain9,
  input  logic [PW-1:0] datain10,
  input  logic [PW-1:0] datain11,
  input  logic [PW-1:0] datain12,
  input  logic [PW-1:0] datain13,
  input  logic [PW-1:0] datain14,
  input  logic [PW-1:0] datain15,
  input  logic          rdy_in,
  input  logic          clr_ovr,
  output logic [OW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          ovr
);

  // 16 products of PW bits need 4 bits of headroom; the 64-bit clip carrier
  // bounds the accumulator width from above.
  if (AW < PW + 4) begin : g_aw_too_small
    $error("fir_tap_accumulator: AW must be at least PW + 4");
  end
  if (AW > 64) begin : g_aw_too_large
    $error("fir_tap_accumulator: AW must not exceed 64");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [PW-1:0] din_arr [NTAPS];
  logic [PW-1:0] bank    [NTAPS];
  logic [1:0]    state;
  logic          rdy_d;
  logic [AW-1:0] acc;
  logic [3:0]    idx;
  logic          start;

  assign din_arr[0]  = datain0;
  assign din_arr[1]  = datain1;
  assign din_arr[2]  = datain2;
  assign din_arr[3]  = datain3;
  assign din_arr[4]  = datain4;
  assign din_arr[5]  = datain5;
  assign din_arr[6]  = datain6;
  assign din_arr[7]  = datain7;
  assign din_arr[8]  = datain8;
  assign din_arr[9]  = datain9;
  assign din_arr[10] = datain10;
  assign din_arr[11] = datain11;
  assign din_arr[12] = datain12;
  assign din_arr[13] = datain13;
  assign din_arr[14] = datain14;
  assign din_arr[15] = datain15;

  // Only the rising edge of the ready level starts a frame, so a ready held
  // high across many cycles yields exactly one result.
  assign start = rdy_in & ~rdy_d;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_d <= 1'b0;
    end else begin
      rdy_d <= rdy_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      dout_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NTAPS; i++) begin
              bank[i] <= din_arr[i];
            end
            acc   <= '0;
            idx   <= '0;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= acc + AW'(bank[idx]);
          idx <= idx + 4'd1;
          if (idx == 4'd15) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          dout       <= OW'(sat_u(64'(acc >> SHIFT), OW));
          dout_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A new overrun in the same cycle as a clear leaves the flag set, so no
  // overrun can slip past software unseen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (start && (state != S_IDLE)) begin
      ovr <= 1'b1;
    end else if (clr_ovr) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
module tb_fir_tap_accumulator;

  localparam int PW = 18;
  localparam int OW = 8;

  typedef struct {
    string            name;
    logic [PW*16-1:0] din;
    logic [OW-1:0]    exp_dout;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] din [16];
  logic          rdy_in;
  logic          clr_ovr;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          ovr;

  int total = 0;
  int bad   = 0;

  fir_tap_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .datain0(din[0]),   .datain1(din[1]),   .datain2(din[2]),   .datain3(din[3]),
    .datain4(din[4]),   .datain5(din[5]),   .datain6(din[6]),   .datain7(din[7]),
    .datain8(din[8]),   .datain9(din[9]),   .datain10(din[10]), .datain11(din[11]),
    .datain12(din[12]), .datain13(din[13]), .datain14(din[14]), .datain15(din[15]),
    .rdy_in(rdy_in), .clr_ovr(clr_ovr),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_din(input logic [PW*16-1:0] flat);
    for (int i = 0; i < 16; i++) din[i] = flat[i*PW +: PW];
  endtask

  function automatic logic [PW*16-1:0] put(input logic [PW*16-1:0] flat, input int i, input logic [PW-1:0] v);
    logic [PW*16-1:0] f;
    f = flat;
    f[i*PW +: PW] = v;
    return f;
  endfunction

  function automatic logic [PW*16-1:0] fill(input logic [PW-1:0] v);
    logic [PW*16-1:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i*PW +: PW] = v;
    return f;
  endfunction

  // Pulse rdy_in for one cycle with the given bank, watch 24 cycles after the
  // start edge. k counts negedges after E0 (k=17 is the cycle after E17).
  // Optionally re-raise rdy_in so the DUT samples it at edge E(rerise_k+1).
  task automatic run_frame(input string name, input logic [PW*16-1:0] flat,
                           input int rerise_k, input bit clr_with,
                           output logic [OW-1:0] got, output int nval, output int vk);
    nval = 0;
    vk   = -1;
    got  = '0;
    @(negedge clk);
    set_din(flat);
    rdy_in = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rdy_in = 1'b0;
        chk({name, "_busy_e0"}, 32'(busy), 32'd1);
      end
      if (k == 16) chk({name, "_busy_e16"}, 32'(busy), 32'd1);
      if (k == 17) chk({name, "_busy_e17"}, 32'(busy), 32'd0);
      if (dout_valid) begin
        nval++;
        if (vk < 0) begin
          vk  = k;
          got = dout;
        end
      end
      if (k == rerise_k) begin
        set_din(fill(18'h3FFFF));
        rdy_in  = 1'b1;
        clr_ovr = clr_with;
      end else if (k == rerise_k + 1) begin
        rdy_in  = 1'b0;
        clr_ovr = 1'b0;
      end
    end
  endtask

  vec_t          vecs [8];
  logic [OW-1:0] got;
  int            nval;
  int            vk;

  initial begin
    rst_n   = 1'b0;
    rdy_in  = 1'b0;
    clr_ovr = 1'b0;
    for (int i = 0; i < 16; i++) din[i] = '0;

    vecs[0] = '{"single_tap", put('0, 0, 18'd1024), 8'd1};
    vecs[1] = '{"centre_taps", put(put('0, 7, 18'd125460), 8, 18'd125460), 8'd245};
    vecs[2] = '{"sat_all", fill(18'd125460), 8'd255};
    vecs[3] = '{"zero", '0, 8'd0};
    vecs[4] = '{"first_last", put(put('0, 0, 18'd1), 15, 18'd1023), 8'd1};
    vecs[5] = '{"below_clip", put('0, 3, 18'd261119), 8'd254};
    vecs[6] = '{"just_over", put(put('0, 2, 18'd131072), 9, 18'd131072), 8'd255};
    vecs[7] = '{"all_max", fill(18'h3FFFF), 8'd255};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].name, vecs[v].din, -10, 1'b0, got, nval, vk);
      chk({vecs[v].name, "_dout"}, 32'(got), 32'(vecs[v].exp_dout));
      chk({vecs[v].name, "_latency"}, 32'(vk), 32'd17);
      chk({vecs[v].name, "_npulse"}, 32'(nval), 32'd1);
      chk({vecs[v].name, "_ovr"}, 32'(ovr), 32'd0);
      chk({vecs[v].name, "_hold"}, 32'(dout), 32'(vecs[v].exp_dout));
    end

    // Level hold: ready high for 40 cycles gives one result, no overrun
    @(negedge clk);
    set_din(put('0, 0, 18'd1024));
    rdy_in = 1'b1;
    nval = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dout_valid) nval++;
    end
    rdy_in = 1'b0;
    chk("hold_npulse", 32'(nval), 32'd1);
    chk("hold_dout", 32'(dout), 32'd1);
    chk("hold_ovr", 32'(ovr), 32'd0);
    repeat (2) @(negedge clk);

    // Re-rise sampled at E5 while accumulating: overrun, result unaffected
    run_frame("ovr_e5", put(put('0, 7, 18'd125460), 8, 18'd125460), 4, 1'b0, got, nval, vk);
    chk("ovr_e5_dout", 32'(got), 32'd245);
    chk("ovr_e5_npulse", 32'(nval), 32'd1);
    chk("ovr_e5_flag", 32'(ovr), 32'd1);
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("clr_ovr", 32'(ovr), 32'd0);

    // Re-rise sampled at E17 (DONE) together with clr_ovr: set wins
    run_frame("ovr_e17", put('0, 5, 18'd4096), 16, 1'b1, got, nval, vk);
    chk("ovr_e17_dout", 32'(got), 32'd4);
    chk("ovr_e17_latency", 32'(vk), 32'd17);
    chk("ovr_e17_npulse", 32'(nval), 32'd1);
    chk("ovr_e17_setwins", 32'(ovr), 32'd1);
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("clr_ovr2", 32'(ovr), 32'd0);

    // Reset mid-frame at E8: everything clears, no pulse for the frame
    @(negedge clk);
    set_din(fill(18'd125460));
    rdy_in = 1'b1;
    nval = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) rdy_in = 1'b0;
      if (dout_valid) nval++;
    end
    // dout still holds 4 from the previous frame here
    chk("pre_rst_dout", 32'(dout), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_ovr", 32'(ovr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dout_valid) nval++;
    end
    chk("midrst_npulse", 32'(nval), 32'd0);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    run_frame("after_rst", put('0, 0, 18'd2048), -10, 1'b0, got, nval, vk);
    chk("after_rst_dout", 32'(got), 32'd2);
    chk("after_rst_latency", 32'(vk), 32'd17);
    chk("after_rst_npulse", 32'(nval), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
